// File: rtl/encoder_host_ctrl.sv
// Host-side sequencer for the Encoder core: buffers one block, runs the
// start/putInput/outReady handshake, streams slices in and drains results.
module encoder_host_ctrl #(
   parameter int SLICES = 64,
   parameter int WIDTH  = 25
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wrEn,
   input  logic [$clog2(SLICES)-1:0]  wrAddr,
   input  logic [WIDTH-1:0]           wrData,
   input  logic                       go,
   output logic                       busy,
   input  logic                       encReady,
   output logic                       encStart,
   input  logic                       encPutInput,
   input  logic                       encOutReady,
   output logic [WIDTH-1:0]           encIn,
   input  logic [WIDTH-1:0]           encOut,
   output logic                       resValid,
   input  logic                       resReady,
   output logic [WIDTH-1:0]           resData,
   output logic [$clog2(SLICES)-1:0]  resIdx,
   output logic                       resLast
);
   localparam int IDXW = $clog2(SLICES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

   typedef enum logic [3:0] {
      IDLE, WAIT_RDY, START, WAIT_PUT, GAP_IN,
      FEED, WAIT_OUT, GAP_OUT, CAPTURE, DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] cnt_q, cnt_d;
   logic            enc_start_q, enc_start_d;
   logic            busy_q, busy_d;
   logic            res_valid_q, res_valid_d;
   logic [IDXW-1:0] res_idx_q, res_idx_d;
   logic            res_last_q, res_last_d;
   logic            feed_d;
   logic            in_we, res_we;
   logic [WIDTH-1:0] enc_in_q, res_data_q;

   logic [WIDTH-1:0] in_buf  [SLICES];
   logic [WIDTH-1:0] res_buf [SLICES];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      enc_start_d = 1'b0;
      in_we       = 1'b0;
      res_we      = 1'b0;
      case (state_q)
         IDLE: begin
            in_we = wrEn;
            if (go) state_d = WAIT_RDY;
         end
         WAIT_RDY: if (encReady) state_d = START;
         // start is held until the core answers by dropping ready
         START: begin
            if (encReady) enc_start_d = 1'b1;
            else          state_d     = WAIT_PUT;
         end
         WAIT_PUT: if (encPutInput) state_d = GAP_IN;
         GAP_IN: begin
            state_d = FEED;
            cnt_d   = '0;
         end
         FEED: begin
            if (cnt_q == LAST_IDX) state_d = WAIT_OUT;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         WAIT_OUT: if (encOutReady) state_d = GAP_OUT;
         GAP_OUT: begin
            state_d = CAPTURE;
            cnt_d   = '0;
         end
         CAPTURE: begin
            res_we = 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (res_valid_q && resReady) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d      = (state_d != IDLE);
      feed_d      = (state_d == FEED);
      res_valid_d = (state_d == DRAIN);
      res_idx_d   = res_valid_d ? cnt_d : '0;
      res_last_d  = res_valid_d && (cnt_d == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         enc_start_q <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         enc_start_q <= enc_start_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_idx_q   <= res_idx_d;
         res_last_q  <= res_last_d;
      end
   end

   // Buffers are never cleared; only the read registers carry reset
   always_ff @(posedge clk) begin
      if (in_we) in_buf[wrAddr] <= wrData;
   end

   always_ff @(posedge clk) begin
      if (res_we) res_buf[cnt_q] <= encOut;
   end

   always_ff @(posedge clk) begin
      if (rst || !feed_d) enc_in_q <= '0;
      else                enc_in_q <= in_buf[cnt_d];
   end

   always_ff @(posedge clk) begin
      if (rst || !res_valid_d) res_data_q <= '0;
      else                     res_data_q <= res_buf[cnt_d];
   end

   assign busy     = busy_q;
   assign encStart = enc_start_q;
   assign encIn    = enc_in_q;
   assign resValid = res_valid_q;
   assign resData  = res_data_q;
   assign resIdx   = res_idx_q;
   assign resLast  = res_last_q;
endmodule

// File: tb/tb_encoder_host_ctrl.sv
// Bench for encoder_host_ctrl: behavioural Encoder core model plus a result
// scoreboard filled when each block is launched.
module tb_encoder_host_ctrl;
   localparam int SLICES = 64;
   localparam int WIDTH  = 25;
   localparam logic [WIDTH-1:0] MASK = 25'h1FFFFFF;

   logic             clk = 1'b0;
   logic             rst, wrEn, go, encReady, encPutInput, encOutReady, resReady;
   logic [5:0]       wrAddr;
   logic [WIDTH-1:0] wrData, encOut;
   logic             busy, encStart, resValid, resLast;
   logic [WIDTH-1:0] encIn, resData;
   logic [5:0]       resIdx;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] inbuf_model [SLICES];
   logic [WIDTH-1:0] core_mem    [SLICES];

   typedef struct {
      logic [5:0]       idx;
      logic [WIDTH-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   encoder_host_ctrl #(.SLICES(SLICES), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .go(go), .busy(busy), .encReady(encReady), .encStart(encStart),
      .encPutInput(encPutInput), .encOutReady(encOutReady), .encIn(encIn),
      .encOut(encOut), .resValid(resValid), .resReady(resReady),
      .resData(resData), .resIdx(resIdx), .resLast(resLast)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic push_block();
      exp_t e;
      for (int k = 0; k < SLICES; k++) begin
         e.idx  = 6'(k);
         e.data = inbuf_model[k] ^ MASK;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_busy_after_go();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_go: got %b required 1", busy);
      end
   endtask

   // Writes the whole model block; the last write shares its cycle with go
   task automatic load_and_go();
      for (int k = 0; k < SLICES; k++) begin
         wrEn   = 1'b1;
         wrAddr = 6'(k);
         wrData = inbuf_model[k];
         go     = (k == SLICES - 1);
         @(negedge clk);
      end
      wrEn = 1'b0;
      go   = 1'b0;
      push_block();
      $display("block launched with load, %0d results expected", SLICES);
      check_busy_after_go();
   endtask

   task automatic go_only();
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      push_block();
      $display("block launched without load, %0d results expected", SLICES);
      check_busy_after_go();
   endtask

   // Core model: entered at the negedge right after the go edge
   task automatic core_run(input int rdy_delay, input int put_delay, input int out_delay,
                           input int abort_at, input bit poke);
      int m;
      bit seen;
      if (rdy_delay > 0) encReady = 1'b0;
      m    = 0;
      seen = 1'b0;
      while (m < 200) begin
         if (encStart === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (m == rdy_delay) encReady = 1'b1;
         @(negedge clk);
         m++;
      end
      checks++;
      if (!seen || m != rdy_delay + 2) begin
         failures++;
         $display("FAIL start_latency: got %0d edges (seen=%0b) required %0d", m, seen, rdy_delay + 2);
         if (!seen) return;
      end
      @(negedge clk);
      checks++;
      if (encStart !== 1'b1) begin
         failures++;
         $display("FAIL start_hold: got %b required 1 while ready high", encStart);
      end
      encReady = 1'b0;
      @(negedge clk);
      checks++;
      if (encStart !== 1'b0) begin
         failures++;
         $display("FAIL start_drop: got %b required 0 after ready low", encStart);
      end
      repeat (put_delay) @(negedge clk);
      encPutInput = 1'b1;
      @(negedge clk);
      encPutInput = 1'b0;
      checks++;
      if (encIn !== '0) begin
         failures++;
         $display("FAIL gap_in: encIn got %h required 0", encIn);
      end
      @(negedge clk);
      for (int k = 0; k < SLICES; k++) begin
         checks++;
         if (encIn !== inbuf_model[k]) begin
            failures++;
            $display("FAIL feed[%0d]: encIn got %h required %h", k, encIn, inbuf_model[k]);
         end
         core_mem[k] = encIn;
         if (poke) begin
            wrEn   = (k == 2);
            wrAddr = 6'd5;
            wrData = 25'h0ABCDEF;
            go     = (k == 20);
         end
         @(negedge clk);
      end
      checks++;
      if (encIn !== '0) begin
         failures++;
         $display("FAIL feed_end: encIn got %h required 0", encIn);
      end
      repeat (out_delay) @(negedge clk);
      encOutReady = 1'b1;
      @(negedge clk);
      encOutReady = 1'b0;
      encOut      = WIDTH'($urandom);
      @(negedge clk);
      for (int k = 0; k < SLICES; k++) begin
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || resValid !== 1'b0 || encIn !== '0 || encStart !== 1'b0) begin
               failures++;
               $display("FAIL abort_reset: busy=%b resValid=%b encIn=%h encStart=%b required all 0",
                        busy, resValid, encIn, encStart);
            end
            rst      = 1'b0;
            encOut   = '0;
            encReady = 1'b1;
            return;
         end
         encOut = core_mem[k] ^ MASK;
         @(negedge clk);
      end
      encOut   = WIDTH'($urandom);
      encReady = 1'b1;
   endtask

   // Consumer: mode 0 keeps resReady high, mode 1 accepts one cycle in three
   task automatic drain(input int mode);
      int   got, cyc, valid_cycles;
      bit   rr, stalled;
      exp_t e;
      logic [WIDTH-1:0] sv_data;
      logic [5:0]       sv_idx;
      logic             sv_last;
      got = 0; cyc = 0; valid_cycles = 0; stalled = 1'b0;
      sv_data = '0; sv_idx = '0; sv_last = 1'b0;
      while (got < SLICES && cyc < 3000) begin
         if (stalled) begin
            checks++;
            if (resValid !== 1'b1 || resData !== sv_data || resIdx !== sv_idx || resLast !== sv_last) begin
               failures++;
               $display("FAIL stall_stable: got v=%b d=%h i=%0d l=%b required v=1 d=%h i=%0d l=%b",
                        resValid, resData, resIdx, resLast, sv_data, sv_idx, sv_last);
            end
         end
         rr       = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         resReady = rr;
         stalled  = 1'b0;
         if (resValid === 1'b1) begin
            valid_cycles++;
            if (rr) begin
               got++;
               $display("result idx=%0d data=%h last=%b", resIdx, resData, resLast);
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL extra_result: got idx %0d required no result", resIdx);
               end else begin
                  e = exp_q.pop_front();
                  if (resData !== e.data || resIdx !== e.idx || resLast !== (e.idx == 6'd63)) begin
                     failures++;
                     $display("FAIL result: got d=%h i=%0d l=%b required d=%h i=%0d l=%b",
                              resData, resIdx, resLast, e.data, e.idx, (e.idx == 6'd63));
                  end
               end
            end else begin
               stalled = 1'b1;
               sv_data = resData;
               sv_idx  = resIdx;
               sv_last = resLast;
            end
         end
         @(negedge clk);
         cyc++;
      end
      resReady = 1'b0;
      checks++;
      if (got != SLICES) begin
         failures++;
         $display("FAIL drain_count: got %0d results required %0d", got, SLICES);
      end
      checks++;
      if (resValid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_exit: resValid=%b busy=%b required 0 0", resValid, busy);
      end
      if (mode == 0) begin
         checks++;
         if (valid_cycles != SLICES) begin
            failures++;
            $display("FAIL drain_length: got %0d valid cycles required %0d", valid_cycles, SLICES);
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left: got %0d pending required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; go = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0;
      encReady = 1'b1; encPutInput = 1'b0; encOutReady = 1'b0; encOut = '0; resReady = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || encStart !== 1'b0 || encIn !== '0 || resValid !== 1'b0 ||
          resData !== '0 || resIdx !== '0 || resLast !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b start=%b in=%h v=%b d=%h i=%0d l=%b required all 0",
                  busy, encStart, encIn, resValid, resData, resIdx, resLast);
      end
      rst = 1'b0;
      go  = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || encStart !== 1'b0) begin
         failures++;
         $display("FAIL go_in_reset: busy=%b encStart=%b required 0 0", busy, encStart);
      end
      $display("reset sequence done");
   endtask

   task automatic test_basic();
      for (int k = 0; k < SLICES; k++) inbuf_model[k] = WIDTH'(k);
      load_and_go();
      fork
         core_run(0, 0, 0, -1, 1'b0);
         drain(0);
      join
   endtask

   task automatic test_handshake_timing();
      for (int k = 0; k < SLICES; k++) inbuf_model[k] = WIDTH'($urandom);
      load_and_go();
      fork
         core_run(5, 3, 2, -1, 1'b0);
         drain(0);
      join
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < SLICES; k++) inbuf_model[k] = WIDTH'($urandom);
      load_and_go();
      fork
         core_run(0, 1, 0, -1, 1'b0);
         drain(1);
      join
   endtask

   task automatic test_lock_ignore();
      bit extra;
      go_only();
      fork
         core_run(0, 0, 0, -1, 1'b1);
         drain(0);
      join
      extra = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (busy !== 1'b0 || encStart !== 1'b0 || resValid !== 1'b0) extra = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (extra) begin
         failures++;
         $display("FAIL second_block: got activity after block required idle");
      end
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < SLICES; k++) inbuf_model[k] = WIDTH'($urandom);
      load_and_go();
      core_run(0, 0, 0, 30, 1'b0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || resValid !== 1'b0) begin
         failures++;
         $display("FAIL after_abort: busy=%b resValid=%b required 0 0", busy, resValid);
      end
      for (int k = 0; k < SLICES; k++) inbuf_model[k] = WIDTH'($urandom);
      load_and_go();
      fork
         core_run(1, 2, 1, -1, 1'b0);
         drain(1);
      join
   endtask

   initial begin
      test_reset();
      test_basic();
      test_handshake_timing();
      test_backpressure();
      test_lock_ignore();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/encoder_host_ctrl.md
# encoder_host_ctrl

Host-side controller for the 25-bit-slice `Encoder` core. It buffers one 64-slice block (64 × 25 bits), performs the core's start / putInput / outReady handshake, streams the block in, captures the 64 result slices, and presents them on a valid/ready stream. It sits between the system datapath and the `Encoder` instance and replaces bench-level sequencing in synthesized designs.

## Interface
- `SLICES`, 64: slices per block; index width is `$clog2(SLICES)`.
- `WIDTH`, 25: bits per slice.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wrEn`  in  1  load-buffer write strobe.
- `wrAddr`  in  6  slice index to write.
- `wrData`  in  WIDTH  slice value.
- `go`  in  1  single-cycle request to process the loaded block.
- `busy`  out  1  high from `go` acceptance until the last result is accepted.
- `encReady`  in  1  core `ready`.
- `encStart`  out  1  core `start`.
- `encPutInput`  in  1  core `putInput`.
- `encOutReady`  in  1  core `outReady`.
- `encIn`  out  WIDTH  slice driven to core `in`.
- `encOut`  in  WIDTH  slice from core `out`.
- `resValid`  out  1  result slice valid.
- `resReady`  in  1  downstream accepts the result slice.
- `resData`  out  WIDTH  result slice.
- `resIdx`  out  6  index of `resData`, 0..63.
- `resLast`  out  1  high with `resValid` when `resIdx == SLICES-1`.

## Operation
- Two SLICES×WIDTH arrays: `inBuf` and `resBuf`. Neither is cleared by reset.
- FSM states: IDLE, WAIT_RDY, START, WAIT_PUT, GAP_IN, FEED, WAIT_OUT, GAP_OUT, CAPTURE, DRAIN.
- IDLE: `wrEn` writes `inBuf[wrAddr]`. `go` moves to WAIT_RDY and sets `busy`.
- While `busy`, `wrEn` is ignored, so `inBuf` is locked.
- If `wrEn` and `go` occur in the same cycle, the write completes and is included in the block.
- WAIT_RDY: wait for `encReady`=1, then go to START.
- START: `encStart`=1. Hold it until `encReady` is sampled 0, then deassert and go to WAIT_PUT.
- WAIT_PUT: wait for `encPutInput`=1, then go to GAP_IN.
- GAP_IN: exactly one idle cycle.
- FEED: 64 consecutive cycles; cycle k drives `encIn = inBuf[k]`. After k=63, go to WAIT_OUT.
- WAIT_OUT: wait for `encOutReady`=1, then go to GAP_OUT.
- GAP_OUT: exactly one idle cycle.
- CAPTURE: 64 consecutive cycles; cycle k writes `resBuf[k] = encOut`. Then go to DRAIN.
- DRAIN: present `resBuf[idx]` with `resValid`=1. `idx` advances only on `resValid & resReady`.
- DRAIN exit: after the handshake with `resLast`, go to IDLE and clear `busy` in the same edge.
- `go` while `busy` is ignored; it is neither queued nor an error.
- Slice counter is 6 bits; it resets to 0 on entry to FEED, CAPTURE and DRAIN. It never wraps inside a state.
- `encIn` is 0 outside FEED.

## Timing
- Reset values: `busy`=0, `encStart`=0, `encIn`=0, `resValid`=0, `resData`=0, `resIdx`=0, `resLast`=0. State is IDLE.
- `rst` asserted mid-operation returns to IDLE on the next edge and aborts the block. Buffer contents are retained and undefined for use.
- `go` sampled at edge t: `busy`=1 after edge t. `encStart` rises at edge t+2 at the earliest, when `encReady` was already high.
- `encPutInput` sampled at edge p: GAP_IN is cycle p+1, and slice 0 appears on `encIn` after edge p+1. Slice k is held for exactly one cycle.
- `encOutReady` sampled at edge q: the slice k capture occurs at edge q+2+k.
- `resData`, `resIdx` and `resLast` are registered and stable while `resValid`=1 and `resReady`=0.
- With `resReady` tied high, DRAIN lasts 64 cycles.
- Throughput is one block per handshake round trip; there is no overlap between blocks.

## Test plan
- Reset: assert `rst` 2 cycles → all outputs 0, `busy`=0. `go` with `rst` high is not accepted.
- Basic block: load `inBuf[k]=k`, pulse `go`; the behavioural core model returns `in ^ 25'h1FFFFFF` → `resData[k]=k^25'h1FFFFFF`, `resIdx` runs 0..63, `resLast` only at 63.
- Handshake timing: model holds `encReady` low 5 cycles after `go`, then `putInput` 3 cycles after start drops → `encStart` is high only while `encReady`=1. The first `encIn` = `inBuf[0]` appears exactly 2 edges after `putInput` is sampled.
- Backpressure: toggle `resReady` 1-of-3 cycles → 64 results in order, none duplicated or dropped, `resData` stable while stalled.
- Lock and ignore: `wrEn` to addr 5 with data 25'h0ABCDEF while `busy`, and a second `go` during FEED → `inBuf[5]` is unchanged and only one block is processed.
- Mid-operation reset: `rst` during CAPTURE at k=30 → IDLE next cycle, `busy`=0. A subsequent full block completes correctly.
